// File: rtl/seq_checker_pkg.sv
// Shared types and helpers for the sequence increment checker.
// Holds the FSM encoding, the default lock depth and modular next-value math.
package seq_checker_pkg;

    typedef enum logic [1:0] {
        ST_UNSYNC  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam int unsigned LOCK_COUNT_DEF = 4;

    // Value + 1 modulo 2^w; all-ones rolls over to zero.
    function automatic logic [63:0] next_val(
        input logic [63:0] v,
        input int unsigned w
    );
        logic [63:0] mask;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v + 64'd1) & mask;
    endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter: sticks at all-ones, clears only on reset.
// Used to tally in-lock sequence breaks.
module seq_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Step by one unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_increment_checker.sv
// Monitors a free-running counter for +1 steps, locks after a run of
// good increments, and reports breaks and wrap-arounds while locked.
module seq_increment_checker
    import seq_checker_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned LOCK_COUNT    = LOCK_COUNT_DEF,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_value,
    output logic                     locked,
    output logic                     wrap_pulse,
    output logic                     err_pulse,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [WIDTH-1:0]         expected
);

    localparam int unsigned CW = $clog2(LOCK_COUNT + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             locked_q, locked_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             err_inc;
    logic [WIDTH-1:0] nxt;
    logic             hold;
    logic             match;

    assign nxt   = WIDTH'(next_val(64'(in_value), WIDTH));
    assign hold  = (in_value == last_q);
    assign match = (in_value == exp_q);

    // Next-state, compare and pulse logic; a repeated value is a stall, not a break.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        err_inc = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                ST_UNSYNC: begin
                    last_d  = in_value;
                    exp_d   = nxt;
                    cnt_d   = '0;
                    state_d = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (hold) begin
                        state_d = state_q;
                    end else if (match) begin
                        last_d = in_value;
                        exp_d  = nxt;
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_d == CW'(LOCK_COUNT)) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        last_d = in_value;
                        exp_d  = nxt;
                        cnt_d  = '0;
                    end
                end
                ST_LOCKED: begin
                    if (hold) begin
                        state_d = state_q;
                    end else if (match) begin
                        last_d = in_value;
                        exp_d  = nxt;
                        wrap_d = (in_value == '0);
                    end else begin
                        err_d   = 1'b1;
                        err_inc = 1'b1;
                        last_d  = in_value;
                        exp_d   = nxt;
                        cnt_d   = '0;
                        state_d = ST_ACQUIRE;
                    end
                end
                default: begin
                    state_d = ST_UNSYNC;
                end
            endcase
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // State and registered outputs; reset overrides any sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_UNSYNC;
            last_q   <= '0;
            exp_q    <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
        end
    end

    seq_sat_counter #(
        .W(ERR_CNT_WIDTH)
    ) u_err_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (err_inc),
        .count(err_count)
    );

    assign locked     = locked_q;
    assign wrap_pulse = wrap_q;
    assign err_pulse  = err_q;
    assign expected   = exp_q;

endmodule

// File: tb/tb_seq_increment_checker.sv
// Scoreboard bench for seq_increment_checker: two instances (lock depth 4
// with a 2-bit error counter, lock depth 1 with an 8-bit one) share stimulus.
module tb_seq_increment_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_value;

    logic       lk0, wp0, ep0;
    logic [1:0] ec0;
    logic [7:0] ex0;
    logic       lk1, wp1, ep1;
    logic [7:0] ec1;
    logic [7:0] ex1;

    always #5 clk = ~clk;

    seq_increment_checker #(
        .WIDTH(8), .LOCK_COUNT(4), .ERR_CNT_WIDTH(2)
    ) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_value),
        .locked(lk0), .wrap_pulse(wp0), .err_pulse(ep0),
        .err_count(ec0), .expected(ex0)
    );

    seq_increment_checker #(
        .WIDTH(8), .LOCK_COUNT(1), .ERR_CNT_WIDTH(8)
    ) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_value),
        .locked(lk1), .wrap_pulse(wp1), .err_pulse(ep1),
        .err_count(ec1), .expected(ex1)
    );

    typedef struct {
        bit seeded;
        bit locked;
        int last;
        int run;
        int errs;
    } model_t;

    typedef struct {
        int locked;
        int wrap;
        int err;
        int errc;
        int expv;
    } obs_t;

    typedef struct {
        obs_t a;
        obs_t b;
    } exp_t;

    model_t m0, m1;
    exp_t   sbq[$];
    int     passed = 0;
    int     total  = 0;
    bit     done   = 0;
    int     last_drv = 0;

    // Reference behaviour: seed, count good steps, lock, flag breaks.
    function automatic obs_t step(inout model_t m, input bit r, input bit v,
                                  input int val, input int lockn, input int emax);
        obs_t o;
        o.wrap = 0;
        o.err  = 0;
        if (r) begin
            m = '{0, 0, 0, 0, 0};
        end else if (v) begin
            if (!m.seeded) begin
                m.seeded = 1;
                m.last   = val;
                m.run    = 0;
            end else if (val == m.last) begin
                // stalled upstream: ignore
            end else if (val == (m.last + 1) % 256) begin
                m.last = val;
                if (m.locked) begin
                    o.wrap = (val == 0);
                end else begin
                    m.run++;
                    if (m.run >= lockn) m.locked = 1;
                end
            end else begin
                if (m.locked) begin
                    o.err  = 1;
                    m.errs = (m.errs < emax) ? m.errs + 1 : emax;
                    m.locked = 0;
                end
                m.last = val;
                m.run  = 0;
            end
        end
        o.locked = m.locked;
        o.errc   = m.errs;
        o.expv   = m.seeded ? (m.last + 1) % 256 : 0;
        return o;
    endfunction

    task automatic send(input bit r, input bit v, input int val);
        exp_t e;
        @(negedge clk);
        rst      = r;
        in_valid = v;
        in_value = val[7:0];
        if (v && !r) last_drv = val;
        e.a = step(m0, r, v, val, 4, 3);
        e.b = step(m1, r, v, val, 1, 255);
        sbq.push_back(e);
    endtask

    task automatic seq(input int start, input int n);
        for (int i = 0; i < n; i++) send(0, 1, (start + i) % 256);
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    // Monitor: pops one expectation per edge and compares every output.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("u0.locked", int'(lk0), e.a.locked);
                chk("u0.wrap",   int'(wp0), e.a.wrap);
                chk("u0.err",    int'(ep0), e.a.err);
                chk("u0.errcnt", int'(ec0), e.a.errc);
                chk("u0.expect", int'(ex0), e.a.expv);
                chk("u1.locked", int'(lk1), e.b.locked);
                chk("u1.wrap",   int'(wp1), e.b.wrap);
                chk("u1.err",    int'(ep1), e.b.err);
                chk("u1.errcnt", int'(ec1), e.b.errc);
                chk("u1.expect", int'(ex1), e.b.expv);
            end
        end
    end

    initial begin
        int r;
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_value = '0;
        m0 = '{0, 0, 0, 0, 0};
        m1 = '{0, 0, 0, 0, 0};
        send(1, 0, 0);
        send(1, 1, 8'h55);
        // acquire
        seq(8'h10, 5);
        // break, relock, then wrap through zero
        seq(8'hFA, 8);
        // gap error and relock
        seq(8'h1B, 5);
        send(0, 1, 8'h22);
        seq(8'h23, 4);
        // hold and stall
        seq(8'h2C, 5);
        for (int i = 0; i < 3; i++) send(0, 1, 8'h30);
        for (int i = 0; i < 5; i++) send(0, 0, 8'h99);
        send(0, 1, 8'h31);
        // saturation: repeated breaks with relock between
        for (int k = 0; k < 4; k++) seq(8'h50 + 16 * k, 5);
        // reset mid-op after two breaks
        send(1, 0, 0);
        seq(8'h60, 5);
        seq(8'h70, 5);
        seq(8'h80, 5);
        send(1, 1, 8'h40);
        send(0, 1, 8'h41);
        seq(8'h42, 4);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) send(1, 1, int'($urandom_range(0, 255)));
            else if ($urandom_range(0, 7) == 0) send(0, 0, int'($urandom_range(0, 255)));
            else if (r < 12) send(0, 1, (last_drv + 1) % 256);
            else if (r == 12) send(0, 1, last_drv);
            else send(0, 1, int'($urandom_range(0, 255)));
        end
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (sbq.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sbq.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending expected 0", sbq.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_increment_checker.md
Name: seq_increment_checker

Overview:
Downstream monitor for a free-running sequence counter, such as an 8-bit register that pre-increments each clock and clears on synchronous reset. It samples the counter value when `in_valid` is high and checks that each new value is the previous value +1, modulo 2^WIDTH. After enough consecutive good increments it declares lock. It also flags sequence breaks, counts errors with saturation, and pulses on wrap-around.

Parameters:
WIDTH, 8, width of the monitored counter value.
LOCK_COUNT, 4, consecutive correct increments required before `locked` asserts; legal range is 1 or more.
ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
clk  input  1  single clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  high when `in_value` is to be sampled this cycle.
in_value  input  WIDTH  counter value from the upstream stage.
locked  output  1  high while the state is LOCKED.
wrap_pulse  output  1  one-cycle pulse on an in-lock wrap from all-ones to 0.
err_pulse  output  1  one-cycle pulse on an in-lock sequence break.
err_count  output  ERR_CNT_WIDTH  saturating count of in-lock breaks.
expected  output  WIDTH  next value the block expects to see.

Behaviour:
- All outputs are registered. Latency is 1 cycle: a sample taken at edge N is reflected in the outputs after edge N.
- Reset (rst=1 at a posedge) takes priority over everything else, including `in_valid`:
  - state = UNSYNC
  - expected = 0, the internal last-value register = 0, match counter = 0
  - locked, wrap_pulse, err_pulse = 0
  - err_count = 0
- `in_valid`=0: no state change; wrap_pulse and err_pulse = 0 that cycle.
- `wrap_pulse` and `err_pulse` default to 0 on every cycle unless set by the rules below.
- Next-value arithmetic: expected = in_value + 1, truncated to WIDTH bits, so all-ones + 1 = 0.
- Hold rule (ACQUIRE and LOCKED only): if `in_value` equals the last sampled value, the sample is ignored entirely. This means no error, no progress and no pulse. A stalled upstream counter is therefore not an error.
- FSM, evaluated only on samples where `in_valid`=1:
  - UNSYNC: capture last = in_value and expected = in_value + 1. Clear the match counter. Go to ACQUIRE.
  - ACQUIRE, on a match (in_value == expected):
    - increment the match counter; update last and expected;
    - when the counter reaches LOCK_COUNT, go to LOCKED (`locked`=1 after this edge).
  - ACQUIRE, on a mismatch that is not a hold:
    - re-seed: last = in_value, expected = in_value + 1, match counter = 0;
    - no err_pulse and err_count unchanged, because the block was not locked.
  - LOCKED, on a match: update last and expected. If in_value == 0, assert wrap_pulse.
  - LOCKED, on a mismatch that is not a hold:
    - assert err_pulse and increment err_count (saturating);
    - re-seed last and expected from in_value; match counter = 0;
    - go to ACQUIRE, so `locked` falls after this edge.
- err_count saturates at 2^ERR_CNT_WIDTH - 1. It never wraps and clears only on rst.
- With LOCK_COUNT=1, a single match after the seed sample locks the block.
- The match counter width is clog2(LOCK_COUNT+1).
- Reset mid-operation behaves exactly like power-up reset. There is no memory of a prior lock.

Decomposition:
- Package `seq_checker_pkg` holds:
  - the state enum typedef (UNSYNC, ACQUIRE, LOCKED) with 2-bit encoding;
  - a localparam default for LOCK_COUNT;
  - the modular next-value function.
- One sub-module, `seq_sat_counter`, parameterized by width, with clk, rst, inc and count ports. It is used for err_count.
- The FSM, compare logic and pulses stay in the top-level module.

Test Plan:
1. Acquire: reset, then feed 0x10, 0x11, 0x12, 0x13, 0x14 on consecutive valid cycles. Required: locked=0 through the 0x13 sample; locked=1 after the 0x14 edge; expected=0x15; err_count=0.
2. Wrap: while locked, feed 0xFE, 0xFF, 0x00, 0x01. Required: wrap_pulse high for exactly one cycle, after the 0x00 edge; err_pulse never asserts; expected=0x02 at the end.
3. Gap: while locked with expected=0x20, feed 0x22. Required: err_pulse for one cycle, err_count=1, locked=0, expected=0x23. Then feed 0x23, 0x24, 0x25, 0x26; required: locked=1 again and err_count stays 1.
4. Hold and stall: while locked with last=0x30, feed 0x30 valid for 3 cycles, then in_valid=0 for 5 cycles, then 0x31. Required: no pulses, locked stays 1, expected moves to 0x32 only after the 0x31 edge.
5. Saturation: with ERR_CNT_WIDTH=2, force 4 in-lock breaks, relocking between each. Required: err_count goes 1, 2, 3, 3, while err_pulse still fires each time.
6. Reset mid-op: while locked with err_count=2, assert rst for one edge with in_valid=1 and in_value=0x40. Required: after that edge, locked=0, err_count=0, expected=0, no pulses, and the next valid sample is treated as a seed.
